// File: rtl/cas_sort_seq.sv
// cas_sort_seq
//   Sequential sorter. It orders NUM_INPUTS unsigned SNG values so that the
//   largest value comes first. A single compare-and-swap unit is shared over
//   time. The unit runs an odd-even transposition schedule: NUM_INPUTS phases,
//   one compare per cycle.
//
// Ports
//   clk         single clock; all state updates on the rising edge
//   rst         synchronous, active-high reset; aborts any job in progress
//   in_valid    producer presents in_data
//   in_ready    block accepts a value (state is LOAD)
//   in_data     value written to slot[load_idx]
//   out_valid   out_data is valid (state is UNLOAD)
//   out_ready   consumer accepts out_data
//   out_data    slot[unload_idx]; slot 0 (the maximum) is sent first
//   out_last    high with out_valid on the final value of a job
//   busy        high in SORT and UNLOAD
//   swap_count  swaps performed in the current or most recent job (saturating)

module cas_sort_seq #(
   parameter int SNG_WIDTH  = 6,
   parameter int NUM_INPUTS = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [SNG_WIDTH-1:0] in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [SNG_WIDTH-1:0] out_data,
   output logic                 out_last,
   output logic                 busy,
   output logic [7:0]           swap_count
);

   localparam int IDX_W = (NUM_INPUTS > 2) ? $clog2(NUM_INPUTS) : 1;
   localparam int PH_W  = $clog2(NUM_INPUTS + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);

   typedef enum logic [1:0] {
      S_LOAD,
      S_SORT,
      S_UNLOAD
   } state_t;

   state_t               state;
   logic [SNG_WIDTH-1:0] slot [NUM_INPUTS];
   logic [IDX_W-1:0]     load_idx;
   logic [IDX_W-1:0]     unload_idx;
   logic [IDX_W-1:0]     pair_idx;
   logic [PH_W-1:0]      phase;

   // Compare-and-swap datapath and schedule stepping
   logic [IDX_W-1:0]     pair_hi;
   logic [SNG_WIDTH-1:0] cmp_a;
   logic [SNG_WIDTH-1:0] cmp_b;
   logic                 borrow;
   logic [SNG_WIDTH-1:0] diff_lo;
   logic                 do_swap;
   logic                 last_pair;
   logic                 sort_done;
   int                   next_phase;

   assign in_ready = (state == S_LOAD);
   assign out_data = slot[unload_idx];

   // NOTE: every variable written here gets a value on every path first, so
   // the block stays purely combinational and no latch is inferred.
   always_comb begin
      pair_hi = pair_idx + 1'b1;
      cmp_a   = slot[pair_idx];
      cmp_b   = slot[pair_hi];
      {borrow, diff_lo} = {1'b0, cmp_a} - {1'b0, cmp_b};
      // A borrow means cmp_a < cmp_b, and the difference is then nonzero.
      // Equal values give no borrow, so they never swap.
      do_swap = borrow && (diff_lo != '0);

      // The current pair is the last one of its phase if no pair (i+2, i+3) fits.
      last_pair = (int'(pair_idx) + 3 >= NUM_INPUTS);

      // Phases with no pairs take no cycles. Only the odd phase for N=2 is
      // empty, so skipping at most one phase is enough.
      next_phase = int'(phase) + 1;
      if ((next_phase % 2) + 1 >= NUM_INPUTS) begin
         next_phase = next_phase + 1;
      end
      sort_done = last_pair && (next_phase >= NUM_INPUTS);
   end

   // NOTE: sequential state uses non-blocking assignments only. All flops then
   // sample the values from before the edge, which keeps the swap of the two
   // slots race-free.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_LOAD;
         load_idx   <= '0;
         unload_idx <= '0;
         pair_idx   <= '0;
         phase      <= '0;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         busy       <= 1'b0;
         swap_count <= '0;
         // NOTE: the slot file is small and is cleared on reset, so out_data
         // reads a defined value immediately after reset.
         for (int k = 0; k < NUM_INPUTS; k++) begin
            slot[k] <= '0;
         end
      end else begin
         case (state)
            S_LOAD: begin
               if (in_valid && in_ready) begin
                  slot[load_idx] <= in_data;
                  if (load_idx == '0) begin
                     swap_count <= '0;
                  end
                  if (load_idx == LAST_IDX) begin
                     state    <= S_SORT;
                     load_idx <= '0;
                     phase    <= '0;
                     pair_idx <= '0;
                     busy     <= 1'b1;
                  end else begin
                     load_idx <= load_idx + 1'b1;
                  end
               end
            end

            S_SORT: begin
               if (do_swap) begin
                  slot[pair_idx] <= cmp_b;
                  slot[pair_hi]  <= cmp_a;
                  if (swap_count != 8'hFF) begin
                     swap_count <= swap_count + 1'b1;
                  end
               end
               if (sort_done) begin
                  state      <= S_UNLOAD;
                  unload_idx <= '0;
                  out_valid  <= 1'b1;
                  out_last   <= (LAST_IDX == '0);
                  phase      <= '0;
                  pair_idx   <= '0;
               end else if (last_pair) begin
                  phase    <= PH_W'(next_phase);
                  pair_idx <= IDX_W'(next_phase % 2);
               end else begin
                  pair_idx <= pair_idx + IDX_W'(2);
               end
            end

            S_UNLOAD: begin
               if (out_ready) begin
                  if (out_last) begin
                     state      <= S_LOAD;
                     out_valid  <= 1'b0;
                     out_last   <= 1'b0;
                     busy       <= 1'b0;
                     unload_idx <= '0;
                     load_idx   <= '0;
                  end else begin
                     unload_idx <= unload_idx + 1'b1;
                     out_last   <= (unload_idx + 1'b1 == LAST_IDX);
                  end
               end
            end

            default: begin
               state <= S_LOAD;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cas_sort_seq.sv
// tb_cas_sort_seq
//   Self-checking bench for cas_sort_seq. When a job is issued, the stimulus
//   side pushes the expected output beats and the expected swap count into
//   queues. The expected beats are the job values sorted in descending order.
//   The expected swap count is the number of inversions in the input order.
//   A separate monitor pops the queues and compares on every output handshake.

module tb_cas_sort_seq;

   localparam int W = 6;
   localparam int N = 3;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic         out_last;
   logic         busy;
   logic [7:0]   swap_count;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [W-1:0] data;
      logic         last;
   } beat_t;

   beat_t exp_q[$];
   int    swap_q[$];

   always #5 clk = ~clk;

   cas_sort_seq #(
      .SNG_WIDTH (W),
      .NUM_INPUTS(N)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy),
      .swap_count(swap_count)
   );

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Compare cycles for an odd-even transposition schedule of N phases
   function automatic int sort_cycles();
      int c = 0;
      for (int p = 0; p < N; p++) begin
         for (int i = p % 2; i + 1 < N; i += 2) begin
            c++;
         end
      end
      return c;
   endfunction

   task automatic push_expect(input logic [W-1:0] v [N]);
      int    q[$];
      int    inv = 0;
      beat_t b;
      for (int k = 0; k < N; k++) begin
         q.push_back(int'(v[k]));
      end
      for (int i = 0; i < N; i++) begin
         for (int j = i + 1; j < N; j++) begin
            if (v[i] < v[j]) inv++;
         end
      end
      q.rsort();
      for (int k = 0; k < N; k++) begin
         b.data = W'(q[k]);
         b.last = (k == N - 1);
         exp_q.push_back(b);
      end
      swap_q.push_back(inv);
   endtask

   // Monitor: a handshake seen at the falling edge completes at the next rising edge
   initial begin
      beat_t b;
      forever begin
         @(negedge clk);
         if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("sb_underflow", exp_q.size(), 1);
            end else begin
               b = exp_q.pop_front();
               check("out_data", out_data, b.data);
               check("out_last", out_last, b.last);
               if (b.last) begin
                  if (swap_q.size() == 0) check("swap_q_underflow", swap_q.size(), 1);
                  else check("swap_count", swap_count, swap_q.pop_front());
               end
            end
         end
      end
   end

   // Drive one job. Returns one time step after the rising edge that took the last beat.
   task automatic load_job(input logic [W-1:0] v [N], input bit gaps, input bit valid_in_sort,
                           input bit expect_out);
      int waited;
      if (expect_out) push_expect(v);
      for (int k = 0; k < N; k++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               in_valid = 1'b0;
               in_data  = W'($urandom);
               @(posedge clk);
               #1;
            end
         end
         in_valid = 1'b1;
         in_data  = v[k];
         waited   = 0;
         @(negedge clk);
         while (!in_ready && waited < 50) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            waited++;
         end
         if (waited >= 50) check("load_timeout", waited, 0);
         @(posedge clk);
         #1;
         if (k == 0) check("swap_clear", swap_count, 0);
      end
      in_valid = valid_in_sort;
      in_data  = W'($urandom);
   endtask

   // Check the SORT window and the cycle in which out_valid rises
   task automatic sort_window();
      int c = sort_cycles();
      for (int k = 1; k <= c + 1; k++) begin
         @(negedge clk);
         if (k <= c) begin
            check("sort_flags", {busy, out_valid, in_ready}, 3'b100);
         end else begin
            check("latency_out_valid", out_valid, 1);
            check("unload_busy", busy, 1);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain(input bit rand_ready);
      bit done = 1'b0;
      int cyc  = 0;
      in_valid = 1'b0;
      while (!done && cyc < 200) begin
         out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
         @(negedge clk);
         done = out_valid && out_ready && out_last;
         @(posedge clk);
         #1;
         cyc++;
      end
      out_ready = 1'b0;
      check("drain_done", done, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] vals [N];
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_last", out_last, 0);
      check("rst_busy", busy, 0);
      check("rst_swap_count", swap_count, 0);
      check("rst_out_data", out_data, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // 5, 40, 17 with a stall at the start of UNLOAD
      vals = '{6'd5, 6'd40, 6'd17};
      load_job(vals, 1'b0, 1'b0, 1'b1);
      sort_window();
      repeat (4) begin
         @(negedge clk);
         check("stall_data", out_data, 40);
         check("stall_valid", out_valid, 1);
         check("stall_in_ready", in_ready, 0);
         @(posedge clk);
         #1;
      end
      drain(1'b0);

      // Reverse order, already sorted, ties
      vals = '{6'd1, 6'd2, 6'd3};
      load_job(vals, 1'b0, 1'b0, 1'b1);
      sort_window();
      drain(1'b0);
      vals = '{6'd63, 6'd30, 6'd0};
      load_job(vals, 1'b0, 1'b0, 1'b1);
      sort_window();
      drain(1'b0);
      vals = '{6'd9, 6'd9, 6'd9};
      load_job(vals, 1'b0, 1'b0, 1'b1);
      sort_window();
      drain(1'b0);

      // Reset pulse on the second SORT cycle aborts the job
      vals = '{6'd5, 6'd40, 6'd17};
      load_job(vals, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_busy", busy, 0);
      check("abort_out_valid", out_valid, 0);
      check("abort_in_ready", in_ready, 1);
      check("abort_swap_count", swap_count, 0);
      @(posedge clk);
      #1;
      vals = '{6'd7, 6'd3, 6'd50};
      load_job(vals, 1'b0, 1'b0, 1'b1);
      sort_window();
      drain(1'b0);

      // Gapped input beats, in_valid held high through SORT, random backpressure
      vals = '{6'd12, 6'd44, 6'd31};
      load_job(vals, 1'b1, 1'b1, 1'b1);
      sort_window();
      drain(1'b1);

      // Randomized jobs; narrow value ranges on odd jobs to produce ties
      for (int j = 0; j < 24; j++) begin
         for (int k = 0; k < N; k++) begin
            vals[k] = W'($urandom_range(0, (j % 2 == 1) ? 3 : 63));
         end
         load_job(vals, ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), 1'b1);
         if (j % 3 == 0) sort_window();
         drain(($urandom_range(0, 1) == 1));
      end

      repeat (3) @(posedge clk);
      check("sb_empty", exp_q.size(), 0);
      check("swap_q_empty", swap_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
